fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the 8-bit FIFO and sends each byte as an asynchronous UART frame (LSB first, 8N1; optional even parity). Sits directly downstream of the FIFO: it watches `empty`, pulses `rd`, captures `Dout`, and shifts it onto a single `tx` line. It lets a producer burst bytes into the FIFO at clock rate while the line drains at baud rate.

---
 rtl/fifo_uart_tx.sv | 148 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a registered-output FIFO: LSB first, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  // state  | meaning
  // IDLE   | line high, waiting for the FIFO to hold a byte
  // FETCH  | fifo_rd high for one cycle
  // LOAD   | FIFO output valid; captured into shift on exit
  // START  | start bit
  // DATA   | 8 data bits, LSB first
  // PARITY | even parity bit (parity build only)
  // STOP   | stop bit; last cycle decides FETCH or IDLE
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    shift;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  // tx is registered from the current state, so the line trails the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      fifo_rd <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state   <= FETCH;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          tx    <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          tx    <= 1'b1;
          shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
          parity <= ^fifo_dout;
`endif
          state <= START;
        end
        START: begin
          tx <= 1'b0;
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= parity;
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          tx      <= 1'b1;
          tx_done <= (baud == BAUD_PRE);
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (!fifo_empty) begin
              state   <= FETCH;
              fifo_rd <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: bench-side FIFO, timeline model of the line, frame decoder.
// Define UART_TX_PARITY_EN to check the parity build.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB        = 11;
  localparam int A5_FRAME  = 'h54A;
  localparam int PERIOD_BB = 46;
`else
  localparam int NB        = 10;
  localparam int A5_FRAME  = 'h34A;
  localparam int PERIOD_BB = 42;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty, fifo_rd, tx, busy, tx_done;
  logic [7:0] fifo_dout = 8'h00;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Eight-deep FIFO with registered output, as seen by the transmitter.
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] mem [8];
  int         rp = 0, wp = 0, cnt = 0;
  logic       do_rd, do_wr;
  assign fifo_empty = (cnt == 0);
  wire full = (cnt == 8);

  always @(posedge clk) begin
    do_rd = fifo_rd && (cnt > 0);
    do_wr = wr && (cnt < 8);
    if (fifo_rd) chk("rd_while_empty", int'(fifo_empty), 0);
    if (do_rd) begin
      fifo_dout <= mem[rp];
      rp <= (rp + 1) % 8;
    end
    if (do_wr) begin
      mem[wp] <= wdata;
      wp <= (wp + 1) % 8;
    end
    cnt <= cnt + int'(do_wr) - int'(do_rd);
  end

  // Model: a byte accepted at edge k owns the line as a timeline; t=1 is the cycle after k.
  logic [7:0] exp_q[$];
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic logic exp_tx(input int t, input logic [7:0] b);
    int off, k;
    off = t - 4;
    if (off < 0) return 1'b1;
    k = off / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
    end else if (!m_active || m_t == FRAME + 2) begin
      if (!fifo_empty && exp_q.size() > 0) begin
        m_active = 1'b1;
        m_t      = 1;
        m_byte   = exp_q.pop_front();
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
    end
  end

  int   rd_cnt = 0, done_cnt = 0, busy_fall = 0, busy_hi = 0, tx_low = 0;
  logic prev_busy = 1'b0;
  logic e_tx;

  always @(negedge clk) begin
    e_tx = m_active ? exp_tx(m_t, m_byte) : 1'b1;
    chk("tx", int'(tx), int'(e_tx));
    chk("fifo_rd", int'(fifo_rd), int'(m_active && m_t == 1));
    chk("busy", int'(busy), int'(m_active));
    chk("tx_done", int'(tx_done), int'(m_active && m_t == FRAME + 2));
    if (fifo_rd) rd_cnt++;
    if (tx_done) done_cnt++;
    if (busy) busy_hi++;
    if (tx !== 1'b1) tx_low++;
    if (prev_busy && !busy) busy_fall++;
    prev_busy = busy;
  end

  // Mid-bit sampling decoder.
  logic        rx_busy = 1'b0, had_frame = 1'b0;
  int          rx_cnt = 0, prev_fall = 0;
  logic [10:0] rx_frm = '0;
  logic [7:0]  rx_q[$];
  int          frm_q[$];
  int          per_q[$];
  logic        par_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      rx_busy   = 1'b0;
      had_frame = 1'b0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_frm  = '0;
        if (had_frame) per_q.push_back(cyc - prev_fall);
        prev_fall = cyc;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) rx_frm[rx_cnt / CPB] = tx;
      if (rx_cnt == FRAME - 1) begin
        rx_busy   = 1'b0;
        had_frame = 1'b1;
        rx_q.push_back(rx_frm[8:1]);
        frm_q.push_back(int'(rx_frm));
        par_q.push_back(rx_frm[9]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (full && n < 2000) begin
      tick();
      n++;
    end
    chk("push_room", int'(full), 0);
    wr    = 1'b1;
    wdata = b;
    exp_q.push_back(b);
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_rx(input int lim);
    int n = 0;
    while (!rx_busy && n < lim) begin
      tick();
      n++;
    end
    chk("rx_start_seen", int'(rx_busy), 1);
  endtask

  task automatic wait_quiet(input int lim);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((busy || !fifo_empty || rx_busy) && n < lim);
    chk("quiet_reached", int'(busy || !fifo_empty || rx_busy), 0);
    repeat (4) tick();
  endtask

  int b_rd, b_done, b_fall, b_hi, b_low;

  task automatic start_test();
    rx_q.delete();
    frm_q.delete();
    per_q.delete();
    par_q.delete();
    had_frame = 1'b0;
    b_rd   = rd_cnt;
    b_done = done_cnt;
    b_fall = busy_fall;
    b_hi   = busy_hi;
    b_low  = tx_low;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_tx", int'(tx), 1);
    chk("rst_rd", int'(fifo_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done), 0);
    rst = 1'b1;

    // idle with empty FIFO
    start_test();
    repeat (1000) tick();
    chk("idle_rd", rd_cnt - b_rd, 0);
    chk("idle_busy", busy_hi - b_hi, 0);
    chk("idle_tx_low", tx_low - b_low, 0);

    // single byte 0xA5
    start_test();
    push(8'hA5);
    wait_quiet(500);
    chk("a5_rd_pulses", rd_cnt - b_rd, 1);
    chk("a5_done_pulses", done_cnt - b_done, 1);
    chk("a5_frames", rx_q.size(), 1);
    chk("a5_byte", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 'hA5);
    chk("a5_bits", frm_q.size() > 0 ? frm_q[0] : -1, A5_FRAME);
    chk("a5_empty_after", int'(fifo_empty), 1);
    chk("a5_busy_after", int'(busy), 0);

    // burst 0x01..0x08
    start_test();
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_quiet(3000);
    chk("burst_frames", rx_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("burst_byte", i < rx_q.size() ? int'(rx_q[i]) : -1, i + 1);
    chk("burst_rd_pulses", rd_cnt - b_rd, 8);
    chk("burst_gaps", per_q.size(), 7);
    for (int i = 0; i < per_q.size(); i++)
      chk("burst_gap_high", per_q[i] - (NB - 1) * CPB, CPB + 2);
    chk("burst_busy_falls", busy_fall - b_fall, 1);

    // late arrival during stop bit
    start_test();
    push(8'h11);
    wait_rx(100);
    repeat ((NB - 1) * CPB) tick();
    push(8'h22);
    wait_quiet(500);
    chk("late_frames", rx_q.size(), 2);
    chk("late_byte0", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 'h11);
    chk("late_byte1", rx_q.size() > 1 ? int'(rx_q[1]) : -1, 'h22);
    chk("late_gap_high", per_q.size() > 0 ? per_q[0] - (NB - 1) * CPB : -1, 6);
    chk("late_busy_falls", busy_fall - b_fall, 1);
    chk("late_rd_pulses", rd_cnt - b_rd, 2);

    // reset during data bit 3 of 0x3C, then 0x55
    start_test();
    push(8'h3C);
    wait_rx(100);
    repeat (4 * CPB + 1) tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_rd", int'(fifo_rd), 0);
    chk("rst_mid_busy", int'(busy), 0);
    push(8'h55);
    repeat (2) tick();
    rst = 1'b1;
    wait_quiet(500);
    chk("rst_frames", rx_q.size(), 1);
    chk("rst_byte", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 'h55);

    // 0x07 then 0x03 back to back
    start_test();
    push(8'h07);
    push(8'h03);
    wait_quiet(500);
    chk("par_frames", rx_q.size(), 2);
    chk("par_byte0", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 'h07);
    chk("par_byte1", rx_q.size() > 1 ? int'(rx_q[1]) : -1, 'h03);
    chk("par_period", per_q.size() > 0 ? per_q[0] : -1, PERIOD_BB);
`ifdef UART_TX_PARITY_EN
    chk("par_bit_07", par_q.size() > 0 ? int'(par_q[0]) : -1, 1);
    chk("par_bit_03", par_q.size() > 1 ? int'(par_q[1]) : -1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got cycle %0d expected finish before it", cyc);
    $fatal(1, "watchdog");
  end

endmodule
